arqte1_mem_arbiter: RTL

- Two-master Avalon-MM arbiter sharing one single-port on-chip RAM slave.
- RAM slave: 12-bit word address, 4-bit byteenable, 32-bit data, unregistered q, so 1-cycle read latency.
- Arbitration is combinational, per cycle, round-robin with a bounded hold.
- Reads are pipelined, with readdatavalid routed back to the issuing master.

---
 rtl/arqte1_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/arqte1_mem_arbiter.sv
// arqte1_mem_arbiter: two-master Avalon-MM arbiter in front of one single-port RAM.
// Selection is combinational and round-robin with a bounded hold. Read data comes back
// one cycle after issue and is flagged to the issuing master.
// Optional feature: define ARB_LOCK_EN to add m0_lock/m1_lock. A locked command pins
// the arbiter to its master until that master issues a command with its lock bit clear.
module arqte1_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
`ifdef ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic              req0;
    logic              req1;
    logic              last;
    logic [HOLD_W-1:0] hold_cnt;
    logic              fresh;
    logic              rd_pend;
    logic              rd_id;
    logic              sel_valid;
    logic              sel;
    logic              sel_write;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
    logic lock_act;
    logic lock_id;
    logic sel_lock;

    assign sel_lock = sel ? m1_lock : m0_lock;

    // Lock tracks the lock bit of every issued command; only the owner can issue while held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_act <= 1'b0;
            lock_id  <= 1'b0;
        end else if (sel_valid) begin
            lock_act <= sel_lock;
            lock_id  <= sel;
        end
    end
`endif

    // Per-cycle selection. Until the first issue after reset, last=1 carries no history,
    // so a tie goes to the other master (M0); afterwards last wins while below the hold cap.
    always_comb begin
        sel_valid = 1'b0;
        sel       = last;
        if (reset_n) begin
`ifdef ARB_LOCK_EN
            if (lock_act) begin
                sel       = lock_id;
                sel_valid = lock_id ? req1 : req0;
            end else
`endif
            if (req0 && req1) begin
                sel_valid = 1'b1;
                if (fresh || (hold_cnt >= HOLD_MAX)) begin
                    sel = ~last;
                end else begin
                    sel = last;
                end
            end else if (req0) begin
                sel_valid = 1'b1;
                sel       = 1'b0;
            end else if (req1) begin
                sel_valid = 1'b1;
                sel       = 1'b1;
            end
        end
    end

    assign sel_write = sel ? m1_write : m0_write;

    // Route the selected master's command to the RAM; everything reads as zero when idle.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = sel_valid;
        mem_write      = sel_valid & sel_write;
        if (sel_valid) begin
            if (sel) begin
                mem_address    = m1_address;
                mem_byteenable = m1_byteenable;
                mem_writedata  = m1_writedata;
            end else begin
                mem_address    = m0_address;
                mem_byteenable = m0_byteenable;
                mem_writedata  = m0_writedata;
            end
        end
    end

    assign mem_clken      = reset_n;
    assign m0_waitrequest = ~(sel_valid & ~sel);
    assign m1_waitrequest = ~(sel_valid & sel);

    // Read data is broadcast; the valid strobe goes only to the issuer and dies under reset.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = reset_n & rd_pend & ~rd_id;
    assign m1_readdatavalid = reset_n & rd_pend & rd_id;

    // Round-robin history and the one-deep read return pipeline.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last     <= 1'b1;
            hold_cnt <= '0;
            fresh    <= 1'b1;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            rd_pend <= sel_valid & ~sel_write;
            rd_id   <= sel;
            if (sel_valid) begin
                fresh <= 1'b0;
                if (sel == last) begin
                    if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end else begin
                    last     <= sel;
                    hold_cnt <= HOLD_ONE;
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule
